// File: rtl/modulation_scheduler.sv
// Three-phase modulator scheduler: produces the modulator angle and the shoot
// strobe at a fixed rate, slews the angular step toward a commanded target,
// and sequences start / stop / fault.
//
//   state | meaning
//   IDLE  | outputs hold, no ticks, waiting for start
//   SLEW  | ticking, cur_step moves one count toward tgt_step per ramp event
//   RUN   | ticking at constant cur_step
//   STOP  | ticking, cur_step ramps down to zero, then IDLE
//   FAULT | no ticks, shoot held low, waits for fault_clr with fault released
`timescale 1ns/1ps
module modulation_scheduler #(
    parameter int unsigned CLK_DIV      = 2400,
    parameter int unsigned RAMP_DIV     = 16,
    parameter logic [11:0] ANGLE_OFFSET = 12'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        fault,
    input  logic        fault_clr,
    input  logic [11:0] step_target,
    input  logic        step_valid,
    output logic        step_ready,
    output logic [11:0] angle,
    output logic        shoot,
    output logic        running,
    output logic        fault_latched,
    output logic [2:0]  state
);

    localparam int CW = (CLK_DIV  > 2) ? $clog2(CLK_DIV)  : 1;
    localparam int RW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SLEW  = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   tgt_step, cur_step, cur_next, tgt_next, phase_acc;
    logic [CW-1:0] count;
    logic [RW-1:0] rcount;
    logic          active, tick, ramp, hs;

    // A fault in the same cycle kills a pending tick so no shoot escapes.
    assign active   = (state_q == S_SLEW) || (state_q == S_RUN) || (state_q == S_STOP);
    assign tick     = active && (count == CNT_LAST) && !fault;
    assign ramp     = tick && (rcount == RAMP_LAST);
    assign hs       = step_valid && step_ready;
    assign tgt_next = hs ? step_target : tgt_step;

    // Step slewing: one count per ramp event, toward target in SLEW, toward zero in STOP.
    always_comb begin
        cur_next = cur_step;
        if (ramp) begin
            if (state_q == S_SLEW) begin
                if (cur_step < tgt_step)
                    cur_next = cur_step + 12'd1;
                else if (cur_step > tgt_step)
                    cur_next = cur_step - 12'd1;
            end else if (state_q == S_STOP && cur_step != 12'd0) begin
                cur_next = cur_step - 12'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; fault overrides everything, then stop, then start.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_SLEW;
                S_SLEW:  if (stop) state_d = S_STOP;
                         else if (cur_next == tgt_next) state_d = S_RUN;
                S_RUN:   if (stop) state_d = S_STOP;
                         else if (hs && step_target != cur_step) state_d = S_SLEW;
                S_STOP:  if (cur_next == 12'd0) state_d = S_IDLE;
                S_FAULT: if (fault_clr) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        step_ready    = (state_q == S_IDLE) || (state_q == S_SLEW) || (state_q == S_RUN);
        running       = active;
        fault_latched = (state_q == S_FAULT);
        state         = state_q;
    end

    // Datapath: target capture, step, phase accumulator, angle, tick and ramp counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_step  <= '0;
            cur_step  <= '0;
            phase_acc <= '0;
            angle     <= '0;
            shoot     <= 1'b0;
            count     <= '0;
            rcount    <= '0;
        end else begin
            tgt_step <= tgt_next;
            shoot    <= tick;
            if (state_q == S_IDLE && state_d == S_SLEW) begin
                cur_step  <= '0;
                phase_acc <= '0;
                count     <= '0;
                rcount    <= '0;
            end else if (state_q == S_FAULT && state_d == S_IDLE) begin
                cur_step  <= '0;
                phase_acc <= '0;
                angle     <= '0;
            end else begin
                cur_step <= cur_next;
                if (active)
                    count <= (count == CNT_LAST) ? '0 : count + 1'b1;
                if (tick) begin
                    phase_acc <= phase_acc + cur_step;
                    angle     <= phase_acc + cur_step + ANGLE_OFFSET;
                    rcount    <= (rcount == RAMP_LAST) ? '0 : rcount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_modulation_scheduler.sv
// Bench for modulation_scheduler: one instance at CLK_DIV=10/RAMP_DIV=2 for
// sequencing, one at RAMP_DIV=1/ANGLE_OFFSET=100 for accumulator wrap.
`timescale 1ns/1ps
module tb_modulation_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, fault, fault_clr, step_valid;
    logic [11:0] step_target;
    logic        step_ready, shoot, running, fault_latched;
    logic [11:0] angle;
    logic [2:0]  state;

    logic        w_start, w_stop, w_fault, w_fault_clr, w_step_valid;
    logic [11:0] w_step_target;
    logic        w_step_ready, w_shoot, w_running, w_fault_latched;
    logic [11:0] w_angle;
    logic [2:0]  w_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [11:0] w_exp_q[$];

    always #5 clk = ~clk;

    modulation_scheduler #(.CLK_DIV(10), .RAMP_DIV(2), .ANGLE_OFFSET(12'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .fault(fault),
        .fault_clr(fault_clr), .step_target(step_target), .step_valid(step_valid),
        .step_ready(step_ready), .angle(angle), .shoot(shoot), .running(running),
        .fault_latched(fault_latched), .state(state)
    );

    modulation_scheduler #(.CLK_DIV(10), .RAMP_DIV(1), .ANGLE_OFFSET(12'd100)) dut_w (
        .clk(clk), .reset(reset), .start(w_start), .stop(w_stop), .fault(w_fault),
        .fault_clr(w_fault_clr), .step_target(w_step_target), .step_valid(w_step_valid),
        .step_ready(w_step_ready), .angle(w_angle), .shoot(w_shoot), .running(w_running),
        .fault_latched(w_fault_latched), .state(w_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every shoot pops one expected angle; a shoot with nothing queued is an error.
    always @(negedge clk) begin
        if (reset) begin
            if (shoot) begin
                if (exp_q.size() > 0) check("angle", 32'(angle), 32'(exp_q.pop_front()));
                else                  check("shoot_unexpected", 32'(shoot), 32'd0);
            end
            if (w_shoot && w_exp_q.size() > 0)
                check("wrap_angle", 32'(w_angle), 32'(w_exp_q.pop_front()));
        end
    end

    task automatic push_seq(input int n, input logic [11:0] a[16]);
        for (int i = 0; i < n; i++) exp_q.push_back(a[i]);
    endtask

    task automatic wait_shoots(input int n, input int budget, input string tag);
        int cnt = 0;
        for (int i = 0; i < budget && cnt < n; i++) begin
            @(negedge clk);
            if (shoot) cnt++;
        end
        check(tag, 32'(cnt), 32'(n));
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == s) break;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    logic [11:0] ramp_up[16];
    logic [11:0] tail[16];

    initial begin
        int phase, cur;
        logic [11:0] a0, a1;
        int seen;

        start = 0; stop = 0; fault = 0; fault_clr = 0; step_valid = 0; step_target = 0;
        w_start = 0; w_stop = 0; w_fault = 0; w_fault_clr = 0; w_step_valid = 0; w_step_target = 0;
        ramp_up = '{12'd0, 12'd0, 12'd1, 12'd2, 12'd4, 12'd6, 12'd9, 12'd12, 12'd15,
                    12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
        tail    = '{12'd18, 12'd20, 12'd22, 12'd23, 12'd24, 12'd0, 12'd0, 12'd0,
                    12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};

        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_angle", 32'(angle), 32'd0);
        check("rst_shoot", 32'(shoot), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(step_ready), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_fault_latched", 32'(fault_latched), 32'd0);
        reset = 1'b1;

        // Soft start to step 3, then stop from RUN.
        @(negedge clk); step_target = 12'd3; step_valid = 1;
        @(negedge clk); step_valid = 0; start = 1;
        push_seq(9, ramp_up);
        @(negedge clk); start = 0;
        check("start_slew", 32'(state), 32'd1);
        check("start_running", 32'(running), 32'd1);
        wait_shoots(6, 80, "ramp_six_shoots");
        check("run_after_ramp", 32'(state), 32'd2);
        wait_shoots(3, 40, "run_three_shoots");
        stop = 1;
        push_seq(5, tail);
        @(negedge clk); stop = 0;
        check("stop_state", 32'(state), 32'd3);
        check("stop_ready", 32'(step_ready), 32'd0);
        check("stop_running", 32'(running), 32'd1);
        wait_state(3'd0, 80, "stop_to_idle");
        check("stop_angle_hold", 32'(angle), 32'd24);
        repeat (30) @(negedge clk);
        check("stop_angle_hold_later", 32'(angle), 32'd24);
        check("stop_queue_drained", 32'(exp_q.size()), 32'd0);

        // Retarget 3 -> 1 while running; target persisted through idle.
        @(negedge clk); start = 1;
        push_seq(9, ramp_up);
        @(negedge clk); start = 0;
        wait_shoots(9, 120, "restart_shoots");
        check("restart_run", 32'(state), 32'd2);
        step_target = 12'd1; step_valid = 1;
        push_seq(5, tail);
        @(negedge clk); step_valid = 0;
        check("retarget_slew", 32'(state), 32'd1);
        wait_shoots(3, 40, "retarget_ramp");
        check("retarget_run", 32'(state), 32'd2);
        wait_shoots(2, 40, "retarget_hold");
        stop = 1;
        exp_q.push_back(12'd25);
        exp_q.push_back(12'd26);
        @(negedge clk); stop = 0;
        wait_state(3'd0, 60, "retarget_stop_idle");
        check("retarget_last_angle", 32'(angle), 32'd26);

        // Fault mid-slew, landing exactly on a tick edge.
        @(negedge clk); step_target = 12'd3; step_valid = 1;
        @(negedge clk); step_valid = 0; start = 1;
        exp_q.push_back(12'd0); exp_q.push_back(12'd0); exp_q.push_back(12'd1);
        @(negedge clk); start = 0;
        wait_shoots(3, 60, "fault_pre_shoots");
        repeat (9) @(negedge clk);
        fault = 1;
        @(negedge clk);
        check("fault_state", 32'(state), 32'd4);
        check("fault_shoot", 32'(shoot), 32'd0);
        check("fault_latched", 32'(fault_latched), 32'd1);
        check("fault_ready", 32'(step_ready), 32'd0);
        check("fault_running", 32'(running), 32'd0);
        check("fault_angle_hold", 32'(angle), 32'd1);
        start = 1;
        @(negedge clk); start = 0;
        check("fault_ignores_start", 32'(state), 32'd4);
        fault_clr = 1;
        @(negedge clk);
        check("fault_clr_while_fault", 32'(state), 32'd4);
        fault = 0;
        @(negedge clk); fault_clr = 0;
        check("fault_exit_idle", 32'(state), 32'd0);
        check("fault_exit_angle", 32'(angle), 32'd0);
        check("fault_exit_latched", 32'(fault_latched), 32'd0);
        repeat (25) @(negedge clk);
        check("fault_queue_drained", 32'(exp_q.size()), 32'd0);

        // Wrap instance: ramp to 2048 one count per tick, offset 100.
        phase = 0; cur = 0;
        for (int k = 0; k < 2052; k++) begin
            w_exp_q.push_back(12'((phase + cur + 100) & 12'hfff));
            phase = (phase + cur) & 12'hfff;
            if (cur < 2048) cur++;
        end
        @(negedge clk); w_step_target = 12'd2048; w_step_valid = 1;
        @(negedge clk); w_step_valid = 0; w_start = 1;
        @(negedge clk); w_start = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (w_state == 3'd2) break;
        end
        check("wrap_run", 32'(w_state), 32'd2);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w_exp_q.size() == 0) break;
        end
        check("wrap_queue_drained", 32'(w_exp_q.size()), 32'd0);
        seen = 0; a0 = '0; a1 = '0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (w_shoot) begin
                if (seen == 0) a0 = w_angle; else a1 = w_angle;
                seen++;
            end
        end
        check("wrap_two_shoots", 32'(seen), 32'd2);
        check("wrap_alternate", 32'((a1 - a0) & 12'hfff), 32'd2048);
        check("wrap_still_run", 32'(w_state), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modulation_scheduler.md
Name: modulation_scheduler

Overview:
- Sequences the three-phase modulator. Generates its `angle` and `shoot` inputs at a fixed update rate.
- Slews the angular step (output frequency) toward a commanded target, so the modulator soft-starts and soft-stops.
- Handles start, stop and fault.
- Sits between the control/UART command layer and the modulator instance, one scheduler per modulator.

Parameters:
- CLK_DIV, 2400, clk cycles per shoot period (>=2)
- RAMP_DIV, 16, shoot ticks per ±1 change of the current step (>=1)
- ANGLE_OFFSET, 0, constant 12-bit phase offset added to the output angle (per-module phase shift)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  start request, sampled each cycle
- stop  in  1  stop request, sampled each cycle
- fault  in  1  external fault, level
- fault_clr  in  1  fault acknowledge
- step_target  in  12  commanded angle increment per shoot
- step_valid  in  1  step_target valid
- step_ready  out  1  scheduler can accept step_target
- angle  out  12  angle to modulator
- shoot  out  1  one-cycle modulator update strobe
- running  out  1  state is SLEW, RUN or STOP
- fault_latched  out  1  high while in FAULT
- state  out  3  IDLE=0, SLEW=1, RUN=2, STOP=3, FAULT=4

Behaviour:
- Reset (reset=0, async): state IDLE; angle, shoot, running, fault_latched = 0; step_ready=1; internal tgt_step, cur_step, phase_acc, tick counter and ramp counter all 0.

Tick generation:
- The tick counter runs 0..CLK_DIV-1 only in SLEW, RUN and STOP; tick = count==CLK_DIV-1.
- Ramp counter counts ticks 0..RAMP_DIV-1; ramp event = tick && rcount==RAMP_DIV-1.

On each tick (registered):
- phase_acc <= phase_acc + cur_step (mod 4096, using the pre-update cur_step).
- angle <= phase_acc + cur_step + ANGLE_OFFSET (mod 4096).
- shoot=1 for exactly one cycle.
- angle changes only on the edge where shoot rises and holds until the next shoot.

Step handshake:
- step_ready=1 in IDLE, SLEW and RUN; 0 in STOP and FAULT.
- valid&&ready loads tgt_step.
- tgt_step persists across stop and idle; it is cleared only by reset.

States:
- IDLE: outputs hold; shoot=0. On start, go to SLEW and clear cur_step, phase_acc and both counters. angle is unchanged until the first tick.
- SLEW: on each ramp event, cur_step moves 1 toward tgt_step. When cur_step==tgt_step (checked every cycle, after update), go to RUN. If tgt_step==0 at start, go to RUN on the next cycle.
- RUN: cur_step is constant. A newly accepted tgt_step != cur_step goes to SLEW.
- STOP: on each ramp event, cur_step decrements. When cur_step==0, go to IDLE; this is immediate if cur_step is already 0. Ticks and shoots continue until IDLE. Last angle holds.
- FAULT: shoot is forced to 0 from the entering edge; no ticks; fault_latched=1. Exit to IDLE only when fault_clr=1 and fault=0, clearing cur_step, phase_acc and angle to 0.

Priorities and boundaries:
- Same-cycle priority: fault > stop > start > step handshake.
- fault enters FAULT from any state on the next edge; a pending tick that cycle is suppressed.
- stop is ignored in IDLE and FAULT; start is ignored outside IDLE.
- A handshake in the same cycle as stop is still accepted but does not affect the STOP ramp.
- No increment saturation is needed: tgt_step is 12-bit and cur_step never passes it. Accumulator wrap is natural mod 4096.
- Asserting reset mid-operation returns everything to reset values immediately; there is no partial shoot pulse.

Test Plan:
- Reset with CLK_DIV=10, RAMP_DIV=2: hold reset=0 for 5 cycles -> angle=0, shoot=0, state=0, step_ready=1, running=0.
- Load step 3 then pulse start -> shoot every 10 cycles, angles 0,0,1,2,4,6,9,12,15; state SLEW then RUN after the 6th tick.
- From RUN at step 3, pulse stop -> cur_step 3,2,1,0 on every 2nd tick, then IDLE. shoot ceases; angle holds its last value; step_ready=0 during STOP.
- In RUN at step 3, send step_target=1 -> SLEW, step falls 3→2→1, then RUN; angle deltas of 3,3,2,2,1,...
- Wrap: ANGLE_OFFSET=100, RAMP_DIV=1, target 2048 -> in RUN, angle alternates between two values differing by 2048 (mod 4096), including the offset.
- Fault mid-SLEW -> next edge state=4, shoot=0, fault_latched=1, step_ready=0. start is ignored; fault_clr while fault=1 is ignored; fault=0 with fault_clr -> IDLE, angle=0.
